// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD screen composer.
package lcd_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Widest line the blank helper covers; the composer slices what it needs.
    localparam int MAX_COLS = 64;
    localparam logic [MAX_COLS*8-1:0] BLANK_LINE = {MAX_COLS{CHAR_SPACE}};

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } lcd_state_e;

endpackage

// File: rtl/lcd_blink_gen.sv
// Blink phase generator: phase starts at 1 and toggles every BLINK_TICKS mclk cycles.
module lcd_blink_gen #(
    parameter int BLINK_TICKS = 10_000_000
) (
    input  logic mclk,
    input  logic rst,
    input  logic restart,
    output logic phase
);

    localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (int'(cnt_q) >= BLINK_TICKS - 1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/lcd_screen_composer.sv
// Selects one of NSCR two-line screens, blanks after changes, latches a frame per frame_req.
// Optional blink masking is built only when LCD_COMPOSER_BLINK_EN is defined.
module lcd_screen_composer
    import lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int NSCR         = 6,
    parameter int BLINK_TICKS  = 10_000_000,
    parameter int BLANK_FRAMES = 1
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic [$clog2(NSCR)-1:0]    scr_sel,
    input  logic [NSCR*COLS*8-1:0]     scr_lineA,
    input  logic [NSCR*COLS*8-1:0]     scr_lineB,
    input  logic [2*COLS-1:0]          blink_mask,
    input  logic                       frame_req,
    output logic [COLS*8-1:0]          lineA,
    output logic [COLS*8-1:0]          lineB,
    output logic                       frame_ack,
    output logic [$clog2(NSCR)-1:0]    cur_scr
);

    localparam int SW = $clog2(NSCR);
    localparam int LW = COLS * 8;
    localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [LW-1:0] SPACES = BLANK_LINE[LW-1:0];

    lcd_state_e       state_q, state_d;
    logic [LW-1:0]    line_a_q, line_a_d, line_b_q, line_b_d;
    logic             ack_q, ack_d;
    logic [SW-1:0]    cur_q, cur_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;

    logic             sel_change;
    logic             vis;
    logic [2*COLS-1:0] mask_eff;
    logic [SW-1:0]    comp_sel;
    logic [LW-1:0]    comp_a, comp_b;

    assign sel_change = (int'(scr_sel) < NSCR) && (scr_sel != cur_q);

`ifdef LCD_COMPOSER_BLINK_EN
    logic blink_phase;

    lcd_blink_gen #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blink (
        .mclk    (mclk),
        .rst     (rst),
        .restart (sel_change),
        .phase   (blink_phase)
    );

    // A frame coincident with a screen change shows the new screen in its visible phase.
    assign vis      = sel_change ? 1'b1 : blink_phase;
    assign mask_eff = blink_mask;
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign vis      = 1'b1;
    assign mask_eff = '0;
`endif

    function automatic logic [LW-1:0] compose(
        input logic [NSCR*LW-1:0] src,
        input logic [SW-1:0]      sel,
        input logic [COLS-1:0]    mask,
        input logic               phase
    );
        logic [LW-1:0] line;
        line = '0;
        for (int i = 0; i < COLS; i++) begin
            line[i*8 +: 8] = (mask[i] && !phase) ? CHAR_SPACE
                                                 : src[(int'(sel) * COLS + i) * 8 +: 8];
        end
        return line;
    endfunction

    assign comp_sel = sel_change ? scr_sel : cur_q;
    assign comp_a   = compose(scr_lineA, comp_sel, mask_eff[COLS-1:0], vis);
    assign comp_b   = compose(scr_lineB, comp_sel, mask_eff[2*COLS-1:COLS], vis);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        bcnt_d   = bcnt_q;
        line_a_d = line_a_q;
        line_b_d = line_b_q;
        ack_d    = 1'b0;

        if (sel_change) begin
            cur_d   = scr_sel;
            bcnt_d  = '0;
            state_d = (BLANK_FRAMES == 0) ? ST_SHOW : ST_BLANK;
            if (frame_req) begin
                ack_d = 1'b1;
                if (BLANK_FRAMES == 0) begin
                    line_a_d = comp_a;
                    line_b_d = comp_b;
                end else begin
                    line_a_d = SPACES;
                    line_b_d = SPACES;
                    bcnt_d   = BW'(1);
                    if (BLANK_FRAMES <= 1) state_d = ST_SHOW;
                end
            end
        end else if (frame_req) begin
            ack_d = 1'b1;
            case (state_q)
                ST_SHOW: begin
                    line_a_d = comp_a;
                    line_b_d = comp_b;
                end
                ST_BLANK: begin
                    line_a_d = SPACES;
                    line_b_d = SPACES;
                    bcnt_d   = bcnt_q + BW'(1);
                    if (int'(bcnt_q) + 1 >= BLANK_FRAMES) state_d = ST_SHOW;
                end
                default: state_d = ST_SHOW;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q  <= ST_SHOW;
            cur_q    <= '0;
            bcnt_q   <= '0;
            line_a_q <= SPACES;
            line_b_q <= SPACES;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            bcnt_q   <= bcnt_d;
            line_a_q <= line_a_d;
            line_b_q <= line_b_d;
            ack_q    <= ack_d;
        end
    end

    assign lineA     = line_a_q;
    assign lineB     = line_b_q;
    assign frame_ack = ack_q;
    assign cur_scr   = cur_q;

endmodule

// File: tb/tb_lcd_screen_composer.sv
// Directed plus randomized bench for lcd_screen_composer against a frame-level reference model.
module tb_lcd_screen_composer;

    localparam int COLS = 16;
    localparam int NSCR = 6;
    localparam int BT   = 4;
    localparam int BF   = 1;
    localparam int SW   = $clog2(NSCR);
    localparam int LW   = COLS * 8;
`ifdef LCD_COMPOSER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic                   mclk = 1'b0;
    logic                   rst;
    logic [SW-1:0]          scr_sel;
    logic [NSCR*LW-1:0]     scr_lineA, scr_lineB;
    logic [2*COLS-1:0]      blink_mask;
    logic                   frame_req;
    logic [LW-1:0]          lineA, lineB;
    logic                   frame_ack;
    logic [SW-1:0]          cur_scr;

    logic [7:0] txt_a [NSCR][COLS];
    logic [7:0] txt_b [NSCR][COLS];

    int total = 0;
    int bad   = 0;

    // Reference model state: committed screen, blank frames still owed, cycles since blink restart.
    logic [LW-1:0] exp_a, exp_b;
    logic          exp_ack;
    int            m_cur, m_blank_left, m_age;

    lcd_screen_composer #(
        .COLS         (COLS),
        .NSCR         (NSCR),
        .BLINK_TICKS  (BT),
        .BLANK_FRAMES (BF)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .scr_sel    (scr_sel),
        .scr_lineA  (scr_lineA),
        .scr_lineB  (scr_lineB),
        .blink_mask (blink_mask),
        .frame_req  (frame_req),
        .lineA      (lineA),
        .lineB      (lineB),
        .frame_ack  (frame_ack),
        .cur_scr    (cur_scr)
    );

    always #5 mclk = ~mclk;

    always_comb begin
        scr_lineA = '0;
        scr_lineB = '0;
        for (int s = 0; s < NSCR; s++) begin
            for (int i = 0; i < COLS; i++) begin
                scr_lineA[(s*COLS + i)*8 +: 8] = txt_a[s][i];
                scr_lineB[(s*COLS + i)*8 +: 8] = txt_b[s][i];
            end
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        bit vis;
        if (rst) begin
            exp_a = {COLS{8'h20}};
            exp_b = {COLS{8'h20}};
            exp_ack = 1'b0;
            m_cur = 0; m_blank_left = 0; m_age = 0;
            return;
        end
        vis = BLINK_EN ? (((m_age / BT) % 2) == 0) : 1'b1;
        if (int'(scr_sel) < NSCR && int'(scr_sel) != m_cur) begin
            m_cur = int'(scr_sel);
            m_blank_left = BF;
            m_age = 0;
            vis = 1'b1;
        end else begin
            m_age++;
        end
        exp_ack = frame_req;
        if (frame_req) begin
            if (m_blank_left > 0) begin
                exp_a = {COLS{8'h20}};
                exp_b = {COLS{8'h20}};
                m_blank_left--;
            end else begin
                for (int i = 0; i < COLS; i++) begin
                    exp_a[i*8 +: 8] = (BLINK_EN && blink_mask[i] && !vis) ? 8'h20 : txt_a[m_cur][i];
                    exp_b[i*8 +: 8] = (BLINK_EN && blink_mask[COLS+i] && !vis) ? 8'h20 : txt_b[m_cur][i];
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge mclk);
        #1;
        check("lineA", lineA, exp_a);
        check("lineB", lineB, exp_b);
        check("frame_ack", LW'(frame_ack), LW'(exp_ack));
        check("cur_scr", LW'(cur_scr), LW'(m_cur));
    endtask

    initial begin
        string title;
        title = "Set Time";
        for (int s = 0; s < NSCR; s++) begin
            for (int i = 0; i < COLS; i++) begin
                txt_a[s][i] = 8'($urandom_range(8'h21, 8'h7e));
                txt_b[s][i] = 8'($urandom_range(8'h21, 8'h7e));
            end
        end
        for (int i = 0; i < COLS; i++) txt_a[0][i] = (i < title.len()) ? title[i] : 8'h20;

        rst = 1'b1; frame_req = 1'b0; scr_sel = '0; blink_mask = '0;
        tick(); tick();

        // First frame of screen 0 after reset release.
        rst = 1'b0; frame_req = 1'b1;
        tick();
        check("char0_S", LW'(lineA[7:0]), LW'(8'h53));
        check("ack_first", LW'(frame_ack), LW'(1'b1));
        frame_req = 1'b0;
        tick();

        // Screen change 0->3: one blank frame, then screen 3 text.
        scr_sel = SW'(3);
        tick();
        frame_req = 1'b1; tick();
        frame_req = 1'b0; tick(); tick();
        frame_req = 1'b1; tick();
        check("cur_scr_3", LW'(cur_scr), LW'(3));
        frame_req = 1'b0; tick();

        // Blink on line-B char0 with a request every cycle.
        blink_mask = 32'h0001_0000;
        txt_b[1][0] = 8'h42;
        scr_sel = SW'(1);
        frame_req = 1'b1;
        repeat (20) tick();

        // Out-of-range selection is ignored.
        scr_sel = SW'(7);
        for (int k = 0; k < 8; k++) begin
            frame_req = k[0];
            tick();
        end

        // Change coincident with a request, then reset in the middle of BLANK.
        scr_sel = SW'(2); frame_req = 1'b1; tick();
        frame_req = 1'b0; tick();
        scr_sel = SW'(4); tick();
        rst = 1'b1; frame_req = 1'b1; tick();
        rst = 1'b0; frame_req = 1'b0; scr_sel = '0; tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            frame_req = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) scr_sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) blink_mask = $urandom;
            txt_a[$urandom_range(0, NSCR-1)][$urandom_range(0, COLS-1)] = 8'($urandom_range(8'h21, 8'h7e));
            txt_b[$urandom_range(0, NSCR-1)][$urandom_range(0, COLS-1)] = 8'($urandom_range(8'h21, 8'h7e));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
